// File: rtl/cache_tag_fifo_mp_if.sv
// Bundle between the cache FSM / fetch pipelines (master) and the tag store (slave).
interface cache_tag_fifo_mp_if #(
  parameter int unsigned TAG_W = 14,
  parameter int unsigned DP    = 8,
  parameter int unsigned NCMP  = 2
);
  localparam int unsigned AW = $clog2(DP);

  logic                   flush;
  logic                   tag_wr;
  logic [TAG_W-1:0]       tag_wdata;
  logic                   tag_inv;
  logic [TAG_W-1:0]       tag_inv_data;
  logic [NCMP-1:0]        cmp_valid;
  logic [NCMP*TAG_W-1:0]  cmp_tag;
  logic [NCMP-1:0]        hit;
  logic [NCMP*AW-1:0]     hit_idx;
  logic [NCMP-1:0]        next_hit;
  logic [AW-1:0]          tag_wptr;
  logic [TAG_W-1:0]       tag_ctag;
  logic                   tag_cvalid;
  logic                   dup_drop;
  logic [AW:0]            vcnt;
  logic                   full;
  logic                   empty;

  modport master (
    output flush, tag_wr, tag_wdata, tag_inv, tag_inv_data, cmp_valid, cmp_tag,
    input  hit, hit_idx, next_hit, tag_wptr, tag_ctag, tag_cvalid, dup_drop,
           vcnt, full, empty
  );

  modport slave (
    input  flush, tag_wr, tag_wdata, tag_inv, tag_inv_data, cmp_valid, cmp_tag,
    output hit, hit_idx, next_hit, tag_wptr, tag_ctag, tag_cvalid, dup_drop,
           vcnt, full, empty
  );
endinterface

// File: rtl/cache_tag_fifo_mp.sv
// Round-robin tag store with per-entry valid bits, invalidate, duplicate
// suppression and NCMP registered lookup ports (hit, lowest hit index, next-line hit).
module cache_tag_fifo_mp #(
  parameter int unsigned TAG_W = 14,
  parameter int unsigned DP    = 8,
  parameter int unsigned NCMP  = 2
) (
  input logic                clk,
  input logic                reset,
  cache_tag_fifo_mp_if.slave bus
);
  localparam int unsigned AW = $clog2(DP);

  logic [TAG_W-1:0]   tag_q [DP];
  logic [TAG_W-1:0]   tag_d [DP];
  logic [DP-1:0]      val_q, val_d;
  logic [AW-1:0]      wptr_q, wptr_d;
  logic [AW:0]        vcnt_q, vcnt_d;
  logic [NCMP-1:0]    hit_q, hit_d;
  logic [NCMP*AW-1:0] idx_q, idx_d;
  logic [NCMP-1:0]    nh_q, nh_d;
  logic               dup_q, dup_d;

  logic [DP-1:0]      wr_match, inv_match;
  logic               do_wr, inc, dec;

  // Match allocate and invalidate tags against valid entries of the pre-edge storage.
  always_comb begin
    wr_match  = '0;
    inv_match = '0;
    for (int unsigned i = 0; i < DP; i++) begin
      wr_match[i]  = val_q[i] && (tag_q[i] == bus.tag_wdata);
      inv_match[i] = val_q[i] && (tag_q[i] == bus.tag_inv_data);
    end
  end

  // Per-port lookup; scanning from the top down leaves the lowest matching index.
  always_comb begin
    logic [TAG_W-1:0] ctag;
    logic [TAG_W-1:0] ntag;
    hit_d = '0;
    idx_d = '0;
    nh_d  = '0;
    for (int unsigned p = 0; p < NCMP; p++) begin
      ctag = bus.cmp_tag[p*TAG_W +: TAG_W];
      ntag = ctag + 1'b1;
      for (int unsigned k = 0; k < DP; k++) begin
        if (val_q[DP-1-k] && tag_q[DP-1-k] == ctag && bus.cmp_valid[p]) begin
          hit_d[p]          = 1'b1;
          idx_d[p*AW +: AW] = AW'(DP-1-k);
        end
        if (val_q[DP-1-k] && tag_q[DP-1-k] == ntag && bus.cmp_valid[p]) begin
          nh_d[p] = 1'b1;
        end
      end
    end
  end

  // Allocate / invalidate next state; a landing write overrides an invalidate of its own slot.
  always_comb begin
    tag_d  = tag_q;
    val_d  = val_q;
    wptr_d = wptr_q;
    dup_d  = bus.tag_wr && (|wr_match);
    do_wr  = bus.tag_wr && !(|wr_match);
    if (bus.tag_inv) begin
      val_d = val_q & ~inv_match;
    end
    if (do_wr) begin
      tag_d[wptr_q] = bus.tag_wdata;
      val_d[wptr_q] = 1'b1;
      wptr_d        = wptr_q + 1'b1;
    end
    inc = do_wr && !val_q[wptr_q];
    dec = bus.tag_inv && (|inv_match) && !(do_wr && inv_match[wptr_q]);
    case ({inc, dec})
      2'b10:   vcnt_d = vcnt_q + 1'b1;
      2'b01:   vcnt_d = vcnt_q - 1'b1;
      default: vcnt_d = vcnt_q;
    endcase
  end

  // State and registered results; flush keeps tag data but clears everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DP; i++) tag_q[i] <= '0;
      val_q  <= '0;
      wptr_q <= '0;
      vcnt_q <= '0;
      hit_q  <= '0;
      idx_q  <= '0;
      nh_q   <= '0;
      dup_q  <= 1'b0;
    end else if (bus.flush) begin
      val_q  <= '0;
      wptr_q <= '0;
      vcnt_q <= '0;
      hit_q  <= '0;
      idx_q  <= '0;
      nh_q   <= '0;
      dup_q  <= 1'b0;
    end else begin
      tag_q  <= tag_d;
      val_q  <= val_d;
      wptr_q <= wptr_d;
      vcnt_q <= vcnt_d;
      hit_q  <= hit_d;
      idx_q  <= idx_d;
      nh_q   <= nh_d;
      dup_q  <= dup_d;
    end
  end

  assign bus.hit        = hit_q;
  assign bus.hit_idx    = idx_q;
  assign bus.next_hit   = nh_q;
  assign bus.dup_drop   = dup_q;
  assign bus.tag_wptr   = wptr_q;
  assign bus.tag_ctag   = tag_q[wptr_q];
  assign bus.tag_cvalid = val_q[wptr_q];
  assign bus.vcnt       = vcnt_q;
  assign bus.full       = (vcnt_q == (AW+1)'(DP));
  assign bus.empty      = (vcnt_q == '0);
endmodule

// File: tb/tb_cache_tag_fifo_mp.sv
// Bench for cache_tag_fifo_mp: directed table of the main scenarios plus random
// traffic, all checked against a behavioural model of the tag store.
module tb_cache_tag_fifo_mp;
  localparam int unsigned TAG_W = 14;
  localparam int unsigned DP    = 8;
  localparam int unsigned NCMP  = 2;
  localparam int unsigned AW    = 3;

  logic clk = 1'b0;
  logic reset;

  cache_tag_fifo_mp_if #(.TAG_W(TAG_W), .DP(DP), .NCMP(NCMP)) bus ();

  cache_tag_fifo_mp #(.TAG_W(TAG_W), .DP(DP), .NCMP(NCMP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model: plain arrays, count derived by counting valid entries.
  logic [TAG_W-1:0]   m_tag [DP];
  bit                 m_val [DP];
  int                 m_wptr;
  logic [NCMP-1:0]    e_hit, e_nh;
  logic [NCMP*AW-1:0] e_idx;
  logic               e_dup;

  typedef struct {
    bit          fl;
    bit          wr;
    logic [13:0] wd;
    bit          inv;
    logic [13:0] id;
    logic [1:0]  cv;
    logic [13:0] c0;
    logic [13:0] c1;
    logic [1:0]  hit;
    logic [2:0]  i0;
    logic [2:0]  i1;
    logic [1:0]  nh;
    bit          dup;
    logic [2:0]  wp;
    logic [3:0]  vc;
    bit          chk_c;
    bit          cvv;
    logic [13:0] ct;
  } vec_t;

  vec_t tbl [24];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int find(input logic [TAG_W-1:0] t);
    for (int i = 0; i < int'(DP); i++)
      if (m_val[i] && m_tag[i] == t) return i;
    return -1;
  endfunction

  function automatic int count_valid();
    int c = 0;
    for (int i = 0; i < int'(DP); i++) if (m_val[i]) c++;
    return c;
  endfunction

  task automatic model_step();
    logic [TAG_W-1:0] ct, nt;
    int f, inv_slot;
    bit wdup;
    if (reset) begin
      for (int i = 0; i < int'(DP); i++) begin m_tag[i] = '0; m_val[i] = 0; end
      m_wptr = 0; e_hit = '0; e_idx = '0; e_nh = '0; e_dup = 1'b0;
      return;
    end
    if (bus.flush) begin
      for (int i = 0; i < int'(DP); i++) m_val[i] = 0;
      m_wptr = 0; e_hit = '0; e_idx = '0; e_nh = '0; e_dup = 1'b0;
      return;
    end
    e_hit = '0; e_idx = '0; e_nh = '0;
    for (int p = 0; p < int'(NCMP); p++) begin
      ct = bus.cmp_tag[p*TAG_W +: TAG_W];
      nt = ct + 1'b1;
      f  = find(ct);
      if (bus.cmp_valid[p] && f >= 0) begin
        e_hit[p] = 1'b1;
        e_idx[p*AW +: AW] = AW'(f);
      end
      e_nh[p] = bus.cmp_valid[p] && (find(nt) >= 0);
    end
    wdup     = bus.tag_wr && (find(bus.tag_wdata) >= 0);
    e_dup    = wdup;
    inv_slot = bus.tag_inv ? find(bus.tag_inv_data) : -1;
    if (inv_slot >= 0) m_val[inv_slot] = 0;
    if (bus.tag_wr && !wdup) begin
      m_tag[m_wptr] = bus.tag_wdata;
      m_val[m_wptr] = 1;
      m_wptr = (m_wptr + 1) % int'(DP);
    end
  endtask

  task automatic check_all();
    int c;
    c = count_valid();
    chk("hit",      32'(bus.hit),      32'(e_hit));
    chk("hit_idx",  32'(bus.hit_idx),  32'(e_idx));
    chk("next_hit", 32'(bus.next_hit), 32'(e_nh));
    chk("dup_drop", 32'(bus.dup_drop), 32'(e_dup));
    chk("tag_wptr", 32'(bus.tag_wptr), 32'(m_wptr));
    chk("vcnt",     32'(bus.vcnt),     32'(c));
    chk("full",     32'(bus.full),     32'(c == int'(DP)));
    chk("empty",    32'(bus.empty),    32'(c == 0));
    chk("tag_cvalid", 32'(bus.tag_cvalid), 32'(m_val[m_wptr]));
    if (m_val[m_wptr]) chk("tag_ctag", 32'(bus.tag_ctag), 32'(m_tag[m_wptr]));
  endtask

  task automatic drive_idle();
    bus.flush = 1'b0; bus.tag_wr = 1'b0; bus.tag_wdata = '0;
    bus.tag_inv = 1'b0; bus.tag_inv_data = '0;
    bus.cmp_valid = '0; bus.cmp_tag = '0;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    logic [13:0] pool_t;
    drive_idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("reset_empty", 32'(bus.empty), 32'd1);
    chk("reset_full",  32'(bus.full),  32'd0);
    chk("reset_vcnt",  32'(bus.vcnt),  32'd0);

    // fl wr wd inv id cv c0 c1 | hit i0 i1 nh dup wp vc chk_c cvv ct
    for (int i = 0; i < 8; i++)
      tbl[i] = '{0, 1, 14'h010 + 14'(i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 3'((i + 1) % 8), 4'(i + 1), (i == 7), 1, 14'h010};
    tbl[8]  = '{0, 0, 0,       0, 0,       2'b11, 14'h013, 14'h017, 2'b11, 3, 7, 2'b01, 0, 0, 8, 0, 0, 0};
    tbl[9]  = '{0, 1, 14'h014, 0, 0,       2'b00, 0,       0,       2'b00, 0, 0, 2'b00, 1, 0, 8, 0, 0, 0};
    tbl[10] = '{0, 0, 0,       0, 0,       2'b00, 0,       0,       2'b00, 0, 0, 2'b00, 0, 0, 8, 0, 0, 0};
    tbl[11] = '{0, 0, 0,       1, 14'h012, 2'b00, 0,       0,       2'b00, 0, 0, 2'b00, 0, 0, 7, 0, 0, 0};
    tbl[12] = '{0, 0, 0,       0, 0,       2'b01, 14'h012, 0,       2'b00, 0, 0, 2'b01, 0, 0, 7, 0, 0, 0};
    tbl[13] = '{0, 1, 14'h030, 0, 0,       2'b00, 0,       0,       2'b00, 0, 0, 2'b00, 0, 1, 7, 0, 0, 0};
    tbl[14] = '{0, 1, 14'h031, 0, 0,       2'b00, 0,       0,       2'b00, 0, 0, 2'b00, 0, 2, 7, 0, 0, 0};
    tbl[15] = '{0, 1, 14'h032, 0, 0,       2'b00, 0,       0,       2'b00, 0, 0, 2'b00, 0, 3, 8, 0, 0, 0};
    tbl[16] = '{0, 1, 14'h033, 0, 0,       2'b00, 0,       0,       2'b00, 0, 0, 2'b00, 0, 4, 8, 0, 0, 0};
    tbl[17] = '{0, 1, 14'h034, 0, 0,       2'b00, 0,       0,       2'b00, 0, 0, 2'b00, 0, 5, 8, 1, 1, 14'h015};
    tbl[18] = '{0, 1, 14'h020, 1, 14'h015, 2'b00, 0,       0,       2'b00, 0, 0, 2'b00, 0, 6, 8, 1, 1, 14'h016};
    tbl[19] = '{0, 0, 0,       0, 0,       2'b11, 14'h015, 14'h020, 2'b10, 0, 5, 2'b01, 0, 6, 8, 0, 0, 0};
    tbl[20] = '{1, 0, 0,       0, 0,       2'b11, 14'h030, 14'h031, 2'b00, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0};
    tbl[21] = '{0, 1, 14'h7FF, 0, 0,       2'b01, 14'h3FFF, 0,      2'b00, 0, 0, 2'b00, 0, 1, 1, 0, 0, 0};
    tbl[22] = '{0, 1, 14'h000, 0, 0,       2'b10, 0,       14'h07FE, 2'b00, 0, 0, 2'b10, 0, 2, 2, 0, 0, 0};
    tbl[23] = '{0, 0, 0,       0, 0,       2'b11, 14'h3FFF, 14'h000, 2'b10, 0, 1, 2'b01, 0, 2, 2, 0, 0, 0};

    for (int r = 0; r < 24; r++) begin
      bus.flush = tbl[r].fl;  bus.tag_wr = tbl[r].wr;  bus.tag_wdata = tbl[r].wd;
      bus.tag_inv = tbl[r].inv; bus.tag_inv_data = tbl[r].id;
      bus.cmp_valid = tbl[r].cv; bus.cmp_tag = {tbl[r].c1, tbl[r].c0};
      step();
      chk($sformatf("t%0d_hit", r),  32'(bus.hit),           32'(tbl[r].hit));
      chk($sformatf("t%0d_idx0", r), 32'(bus.hit_idx[2:0]),  32'(tbl[r].i0));
      chk($sformatf("t%0d_idx1", r), 32'(bus.hit_idx[5:3]),  32'(tbl[r].i1));
      chk($sformatf("t%0d_nh", r),   32'(bus.next_hit),      32'(tbl[r].nh));
      chk($sformatf("t%0d_dup", r),  32'(bus.dup_drop),      32'(tbl[r].dup));
      chk($sformatf("t%0d_wptr", r), 32'(bus.tag_wptr),      32'(tbl[r].wp));
      chk($sformatf("t%0d_vcnt", r), 32'(bus.vcnt),          32'(tbl[r].vc));
      chk($sformatf("t%0d_full", r), 32'(bus.full),          32'(tbl[r].vc == 4'd8));
      chk($sformatf("t%0d_empty", r), 32'(bus.empty),        32'(tbl[r].vc == 4'd0));
      if (tbl[r].chk_c) begin
        chk($sformatf("t%0d_cvalid", r), 32'(bus.tag_cvalid), 32'(tbl[r].cvv));
        if (tbl[r].cvv) chk($sformatf("t%0d_ctag", r), 32'(bus.tag_ctag), 32'(tbl[r].ct));
      end
    end

    // Random traffic from a small tag pool (includes 0x3FFE/0x3FFF for wrap).
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      bus.flush = ($urandom_range(0, 99) == 0);
      bus.tag_wr = ($urandom_range(0, 1) == 1);
      pool_t = 14'($urandom_range(0, 11)) - 14'd2;
      bus.tag_wdata = pool_t;
      bus.tag_inv = ($urandom_range(0, 9) < 3);
      pool_t = 14'($urandom_range(0, 11)) - 14'd2;
      bus.tag_inv_data = ($urandom_range(0, 3) == 0) ? bus.tag_wdata : pool_t;
      bus.cmp_valid = 2'($urandom_range(0, 3));
      for (int p = 0; p < int'(NCMP); p++) begin
        pool_t = 14'($urandom_range(0, 11)) - 14'd2;
        bus.cmp_tag[p*TAG_W +: TAG_W] = pool_t;
      end
      step();
    end
    reset = 1'b0;
    drive_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_tag_fifo_mp.md
Name: cache_tag_fifo_mp

Overview:
Next-generation tag store for the instruction/data cache controllers.
- Holds DP tag entries in a round-robin (FIFO) replacement buffer, each with its own valid bit.
- Serves NCMP independent compare ports with registered hit, hit-index and next-line-hit results.
- Adds features the current tag FIFO lacks: per-tag invalidate with a true valid count (decrement), duplicate-allocation suppression, and multiple lookup ports for fetch plus prefetch.
- Sits between the cache FSM (allocate/invalidate) and the fetch/prefetch pipelines (lookup).

Parameters:
- TAG_W, 14, tag width in bits (4..32).
- DP, 8, number of entries; power of 2, 2..64. AW = $clog2(DP).
- NCMP, 2, number of compare ports (1..4).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  clears all valid bits, pointer and count.
- tag_wr  in  1  allocate tag_wdata at tag_wptr.
- tag_wdata  in  TAG_W  tag to allocate.
- tag_inv  in  1  invalidate the entry whose valid tag equals tag_inv_data.
- tag_inv_data  in  TAG_W  tag to invalidate.
- cmp_valid  in  NCMP  per-port lookup request.
- cmp_tag  in  NCMP*TAG_W  per-port lookup tag; port p occupies bits [p*TAG_W +: TAG_W].
- hit  out  NCMP  registered hit per port.
- hit_idx  out  NCMP*AW  registered index of the lowest-numbered matching entry per port.
- next_hit  out  NCMP  registered hit for cmp_tag+1 (modulo 2^TAG_W) per port.
- tag_wptr  out  AW  next victim location.
- tag_ctag  out  TAG_W  tag currently stored at tag_wptr (victim tag, combinational from storage).
- tag_cvalid  out  1  valid bit at tag_wptr.
- dup_drop  out  1  registered one-cycle pulse: a tag_wr was dropped as a duplicate.
- vcnt  out  AW+1  number of valid entries.
- full  out  1  vcnt==DP.
- empty  out  1  vcnt==0.

Behaviour:
- Reset (synchronous, highest priority): all valid bits 0, tag storage 0, tag_wptr=0, vcnt=0, hit/next_hit/hit_idx/dup_drop=0, empty=1, full=0.
- Priority per cycle: reset > flush > {tag_wr, tag_inv, compare}. Flush has the same effect as reset on valid bits, pointer, count and all registered outputs. Tag data contents are don't-care after flush.
- Snapshot rule: compare, duplicate check and invalidate matching all use storage contents from before this cycle's edge. There is no write-to-compare bypass.
- Compare pipeline, 1-cycle latency. For port p in cycle N:
  - hit[p] = cmp_valid[p] and some valid entry equals cmp_tag[p].
  - hit_idx[p] = lowest matching index, or 0 if no match.
  - next_hit[p] = cmp_valid[p] and some valid entry equals cmp_tag[p]+1 (TAG_W-bit wrap).
  - All three are presented in cycle N+1. If cmp_valid[p]=0, that port's outputs are 0 in N+1.
- Allocate (tag_wr=1):
  - If tag_wdata already matches a valid entry, the write is dropped: storage and tag_wptr are unchanged and dup_drop=1 next cycle.
  - Otherwise entry[tag_wptr] gets tag_wdata with valid=1, and tag_wptr advances by 1, wrapping DP-1 -> 0.
  - Allocating while full overwrites the valid victim; vcnt is unchanged.
- Invalidate (tag_inv=1): the matching valid entry (at most one, guaranteed by duplicate suppression) has its valid bit cleared. No match means no effect. tag_wptr is never moved by an invalidate.
- vcnt update = +1 if a non-dropped write lands on an invalid slot; -1 if an invalidate clears a slot other than the current write target. Net range is clamped by construction to 0..DP.
- Simultaneous tag_wr and tag_inv:
  - If the invalidate hits the write target slot, the write wins: the slot is valid with tag_wdata and vcnt is unchanged.
  - If tag_inv_data == tag_wdata and that tag is valid, the write is dropped as a duplicate and the invalidate clears the slot: vcnt decrements and dup_drop pulses.
- full and empty are derived combinationally from the vcnt register. Invalidated holes are not compacted; they are refilled only when tag_wptr reaches them.
- Flush or reset asserted in the same cycle as a compare: that compare's results are discarded, and outputs are 0 in the next cycle.
- tag_ctag and tag_cvalid always reflect the current tag_wptr slot. The cache FSM reads them in the cycle before allocation for writeback/eviction.

Test Plan:
- Reset, then allocate tags 0x010..0x017 (DP=8) -> tag_wptr wraps to 0, vcnt=8, full=1, empty=0; tag_ctag=0x010.
- Port0 cmp_tag=0x013, port1 cmp_tag=0x017, both valid -> next cycle hit=2'b11, hit_idx0=3, hit_idx1=7; next_hit0=1, next_hit1=0.
- tag_wr 0x014 while 0x014 is valid -> dup_drop pulses once, tag_wptr and vcnt unchanged.
- tag_inv 0x012 -> vcnt 8->7, full=0; compare 0x012 misses. Three further allocates: the first overwrites the valid 0x010 slot (vcnt stays 7), the second lands on slot 1 and overwrites 0x011, the third lands on slot 2 (the hole left by 0x012) and brings vcnt to 8.
- Same cycle: tag_wr 0x020 with wptr=5 holding 0x015, plus tag_inv 0x015 -> slot 5=0x020 valid, vcnt unchanged, 0x015 misses.
- Compare and flush in the same cycle with vcnt=8 -> next cycle hit=0, vcnt=0, empty=1, tag_wptr=0; a following tag_wr 0x7FF with cmp_tag 0x3FFF in the same cycle gives next_hit=0 (no bypass), then 0x3FFF+1 wraps to 0x0000.
